xor_stream_ctrl: RTL and testbench

- Stream controller wrapped around the byte XOR encryption stage; sits directly upstream of the encrypter and also collects its results.
- Accepts plaintext bytes on a valid/ready stream and holds the session key.
- Generates a per-byte rotation amount and drives the encrypter's key/shift/data inputs with the correct skew.
- Re-times the encrypter's free-running output into a back-pressurable ciphertext stream with packet framing preserved.

---
 rtl/xor_stream_ctrl.sv | 190 +++++++++++++++++++
 tb/tb_xor_stream_ctrl.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/xor_stream_ctrl.sv
// xor_stream_ctrl
// Stream controller wrapped around the byte XOR/rotate encrypter. It accepts
// plaintext on a valid/ready stream and holds the session key. It drives the
// encrypter's key/shift/data inputs with the skew the encrypter expects. It
// collects the free-running encrypter output into a small FIFO, which it
// presents as a back-pressurable ciphertext stream with packet framing.
//
// Ports:
//   clk, rst                   clock, synchronous active-high reset
//   key_valid/key_data/key_ready   session key load handshake
//   s_valid/s_data/s_last/s_ready  plaintext byte stream in
//   enc_key/enc_shift/enc_din      registered drive to the encrypter
//   enc_dout                       ciphertext from the encrypter (ENC_LAT after shift)
//   m_valid/m_data/m_last/m_ready  ciphertext byte stream out
//   busy                           any byte in flight or buffered
//
// Optional build macro: XOR_STREAM_SEED_SHIFT_EN
//   When defined, each packet's rotation starts at key[2:0] instead of 0.
//
// Constraints: ENC_LAT >= 2; OUT_DEPTH is a power of two, >= 4.
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | no key loaded; only a key load is accepted
// RUN   | accepting plaintext while output credit remains
// GAP   | packet boundary; new key (once drained) or next packet

module xor_stream_ctrl #(
  parameter int OUT_DEPTH = 4,
  parameter int ENC_LAT   = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_valid,
  input  logic [7:0] key_data,
  output logic       key_ready,
  input  logic       s_valid,
  input  logic [7:0] s_data,
  input  logic       s_last,
  output logic       s_ready,
  output logic [7:0] enc_key,
  output logic [2:0] enc_shift,
  output logic [7:0] enc_din,
  input  logic [7:0] enc_dout,
  output logic       m_valid,
  output logic [7:0] m_data,
  output logic       m_last,
  input  logic       m_ready,
  output logic       busy
);

  localparam int AW = $clog2(OUT_DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    GAP  = 2'd2
  } state_e;

  state_e           state_q;
  logic [2:0]       idx_q;
  // Tag pipeline: bit k set means a byte accepted k+1 edges ago is in flight.
  logic [ENC_LAT:0] tv_q;
  logic [ENC_LAT:0] tl_q;
  logic [7:0]       dp_q [0:ENC_LAT-2];

  logic [8:0]       fifo_q [0:OUT_DEPTH-1];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [CW-1:0]    cnt_q;
  logic [CW-1:0]    cnt_d;

  int               inflight;
  logic             s_fire;
  logic             k_fire;
  logic             push;
  logic             pop;
  logic [2:0]       seed_new;
  logic [2:0]       seed_cur;

`ifdef XOR_STREAM_SEED_SHIFT_EN
  assign seed_new = key_data[2:0];
  assign seed_cur = enc_key[2:0];
`else
  assign seed_new = 3'd0;
  assign seed_cur = 3'd0;
`endif

  always_comb begin
    inflight = 0;
    for (int k = 0; k <= ENC_LAT; k++) begin
      inflight = inflight + (tv_q[k] ? 1 : 0);
    end
  end

  // Credit covers bytes still inside the encrypter, since it cannot stall.
  assign s_ready   = (state_q == RUN) && ((int'(cnt_q) + inflight) < OUT_DEPTH);
  assign key_ready = (state_q == IDLE) || ((state_q == GAP) && (tv_q == '0));
  assign s_fire    = s_valid & s_ready;
  assign k_fire    = key_valid & key_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      idx_q     <= 3'd0;
      tv_q      <= '0;
      tl_q      <= '0;
      enc_key   <= 8'h00;
      enc_shift <= 3'd0;
      enc_din   <= 8'h00;
      for (int k = 0; k < ENC_LAT - 1; k++) dp_q[k] <= 8'h00;
    end else begin
      tv_q <= {tv_q[ENC_LAT-1:0], s_fire};
      tl_q <= {tl_q[ENC_LAT-1:0], s_fire & s_last};

      // Data trails the shift by ENC_LAT-1 cycles; enc_din holds when idle.
      if (s_fire) dp_q[0] <= s_data;
      for (int k = 1; k < ENC_LAT - 1; k++) begin
        if (tv_q[k-1]) dp_q[k] <= dp_q[k-1];
      end
      if (tv_q[ENC_LAT-2]) enc_din <= dp_q[ENC_LAT-2];

      case (state_q)
        IDLE: begin
          if (k_fire) begin
            enc_key <= key_data;
            idx_q   <= seed_new;
            state_q <= RUN;
          end
        end
        RUN: begin
          if (s_fire) begin
            enc_shift <= idx_q;
            if (s_last) begin
              idx_q   <= seed_cur;
              state_q <= GAP;
            end else begin
              idx_q <= idx_q + 3'd1;
            end
          end
        end
        GAP: begin
          if (k_fire) begin
            enc_key <= key_data;
            idx_q   <= seed_new;
            state_q <= RUN;
          end else if (s_valid) begin
            state_q <= RUN;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign push = tv_q[ENC_LAT];
  assign pop  = m_valid & m_ready;

  always_comb begin
    cnt_d = cnt_q;
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      for (int k = 0; k < OUT_DEPTH; k++) fifo_q[k] <= 9'h000;
    end else begin
      if (push) begin
        fifo_q[wr_ptr_q] <= {tl_q[ENC_LAT], enc_dout};
        wr_ptr_q         <= wr_ptr_q + 1'b1;
      end
      if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
      cnt_q <= cnt_d;
    end
  end

  assign m_valid = (cnt_q != '0);
  assign m_data  = fifo_q[rd_ptr_q][7:0];
  assign m_last  = fifo_q[rd_ptr_q][8];
  assign busy    = (tv_q != '0) || (cnt_q != '0);

endmodule

// File: tb/tb_xor_stream_ctrl.sv
module tb_xor_stream_ctrl;

  localparam int DEPTH = 4;
  localparam int LAT   = 2;
`ifdef XOR_STREAM_SEED_SHIFT_EN
  localparam int SEED_MASK = 7;
`else
  localparam int SEED_MASK = 0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       key_valid = 1'b0;
  logic [7:0] key_data = 8'h00;
  logic       s_valid = 1'b0;
  logic [7:0] s_data = 8'h00;
  logic       s_last = 1'b0;
  logic       m_ready = 1'b1;
  logic [7:0] enc_dout = 8'h00;
  logic       key_ready, s_ready, m_valid, m_last, busy;
  logic [7:0] enc_key, enc_din, m_data;
  logic [2:0] enc_shift;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic rnd_mr = 1'b0;

  xor_stream_ctrl #(.OUT_DEPTH(DEPTH), .ENC_LAT(LAT)) dut (
    .clk(clk), .rst(rst),
    .key_valid(key_valid), .key_data(key_data), .key_ready(key_ready),
    .s_valid(s_valid), .s_data(s_data), .s_last(s_last), .s_ready(s_ready),
    .enc_key(enc_key), .enc_shift(enc_shift), .enc_din(enc_din), .enc_dout(enc_dout),
    .m_valid(m_valid), .m_data(m_data), .m_last(m_last), .m_ready(m_ready),
    .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] rotl(input logic [7:0] v, input int s);
    logic [15:0] t;
    t = {v, v} << s;
    return t[15:8];
  endfunction

  function automatic int seed_of(input logic [7:0] k);
    return int'(k[2:0]) & SEED_MASK;
  endfunction

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk9(input string tag, input logic [8:0] obs, input logic [8:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chki(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Encrypter stand-in: latches shift and key one cycle after they are driven,
  // combines them with enc_din on the next edge.
  logic [2:0] e_sh_q = 3'd0;
  logic [7:0] e_key_q = 8'h00;
  always @(posedge clk) begin
    e_sh_q   <= enc_shift;
    e_key_q  <= enc_key;
    enc_dout <= rotl(enc_din ^ e_key_q, int'(e_sh_q));
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Reference model: counts bytes owed downstream, remembers the edge each
  // byte was taken, and predicts the ciphertext from key and packet position.
  logic [8:0] exp_q[$];
  int         acc_t[$];
  logic [8:0] popped[$];
  int         outstanding = 0;
  int         mst = 0;
  int         base = 0;
  int         pos = 0;
  logic [7:0] mkey = 8'h00;
  logic       prev_stall = 1'b0;
  logic [8:0] prev_head = 9'h000;

  initial forever begin
    int   infl;
    logic exp_sr, exp_kr;
    @(negedge clk);
    if (rst) begin
      exp_q.delete();
      acc_t.delete();
      outstanding = 0;
      mst = 0;
      pos = 0;
      base = 0;
      prev_stall = 1'b0;
    end else begin
      while (acc_t.size() > 0 && (cyc - acc_t[0]) >= LAT + 1) void'(acc_t.pop_front());
      infl   = acc_t.size();
      exp_sr = (mst == 1) && (outstanding < DEPTH);
      exp_kr = (mst == 0) || ((mst == 2) && (infl == 0));
      chk1("s_ready", s_ready, exp_sr);
      chk1("key_ready", key_ready, exp_kr);
      chk1("m_valid", m_valid, (outstanding - infl) > 0);
      chk1("busy", busy, outstanding > 0);
      if (prev_stall) chk9("m_hold", {m_last, m_data}, prev_head);
      prev_stall = m_valid && !m_ready;
      prev_head  = {m_last, m_data};
      if (m_valid && m_ready) begin
        if (exp_q.size() > 0) begin
          chk9("m_stream", {m_last, m_data}, exp_q[0]);
          void'(exp_q.pop_front());
          outstanding--;
        end
        popped.push_back({m_last, m_data});
      end
      case (mst)
        0: if (key_valid) begin
          mkey = key_data; base = seed_of(key_data); pos = 0; mst = 1;
        end
        1: if (s_valid && exp_sr) begin
          exp_q.push_back({s_last, rotl(s_data ^ mkey, (base + pos) % 8)});
          acc_t.push_back(cyc + 1);
          outstanding++;
          if (s_last) begin pos = 0; mst = 2; end
          else pos++;
        end
        default: begin
          if (key_valid && exp_kr) begin
            mkey = key_data; base = seed_of(key_data); pos = 0; mst = 1;
          end else if (s_valid) begin
            mst = 1;
          end
        end
      endcase
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (rnd_mr) m_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic send_byte(input logic [7:0] d, input logic l);
    int   t = 0;
    logic ok = 1'b0;
    s_valid = 1'b1; s_data = d; s_last = l;
    forever begin
      @(negedge clk);
      ok = s_ready;
      tick();
      if (ok || t >= 200) break;
      t++;
    end
    chk1("send_accept", ok, 1'b1);
    s_valid = 1'b0; s_last = 1'b0;
  endtask

  task automatic load_key(input logic [7:0] k);
    int   t = 0;
    logic ok = 1'b0;
    key_valid = 1'b1; key_data = k;
    forever begin
      @(negedge clk);
      ok = key_ready;
      tick();
      if (ok || t >= 200) break;
      t++;
    end
    chk1("key_accept", ok, 1'b1);
    key_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int t = 0;
    @(negedge clk);
    while (busy && t < 300) begin
      @(negedge clk);
      t++;
    end
    chk1("drain", busy, 1'b0);
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  logic [7:0] t2tab [0:7] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80};
  logic [7:0] d10 [0:9];
  logic [7:0] b0;

  initial begin
    int len;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    @(negedge clk);
    chk8("rst_enc_key", enc_key, 8'h00);
    chk8("rst_enc_shift", {5'd0, enc_shift}, 8'h00);
    chk8("rst_enc_din", enc_din, 8'h00);
    chk9("rst_m_head", {m_last, m_data}, 9'h000);
    chk1("rst_key_ready", key_ready, 1'b1);
    tick();

    // Single-byte packet with key A5
    load_key(8'hA5);
    send_byte(8'h3C, 1'b1);
    @(negedge clk);
    chk8("t1_shift", {5'd0, enc_shift}, 8'(5 & SEED_MASK));
    chk1("t1_mvalid_n0", m_valid, 1'b0);
    @(negedge clk);
    chk8("t1_din", enc_din, 8'h3C);
    @(negedge clk);
    chk1("t1_mvalid_n2", m_valid, 1'b0);
    @(negedge clk);
    chk1("t1_mvalid_n3", m_valid, 1'b1);
    chk8("t1_mdata", m_data, rotl(8'h99, 5 & SEED_MASK));
    chk1("t1_mlast", m_last, 1'b1);
    tick();
    wait_idle();

    // Nine zero bytes with key 01: rotation wraps after eight
    load_key(8'h01);
    popped.delete();
    for (int i = 0; i < 9; i++) send_byte(8'h00, i == 8);
    wait_idle();
    chki("t2_count", popped.size(), 9);
    for (int i = 0; i < 9 && i < popped.size(); i++) begin
      chk9("t2_byte", popped[i], {i == 8, t2tab[(i + (1 & SEED_MASK)) % 8]});
    end

    // Ten-byte burst against a stalled sink
    m_ready = 1'b0;
    popped.delete();
    for (int i = 0; i < 10; i++) d10[i] = 8'($urandom);
    for (int i = 0; i < 4; i++) send_byte(d10[i], 1'b0);
    s_valid = 1'b1; s_data = d10[4];
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk1("t3_credit_stop", s_ready, 1'b0);
      tick();
    end
    m_ready = 1'b1;
    for (int i = 4; i < 10; i++) send_byte(d10[i], i == 9);
    wait_idle();
    chki("t3_count", popped.size(), 10);
    if (popped.size() == 10) chk1("t3_last", popped[9][8], 1'b1);

    // Key change between packets waits for the pipe to empty
    popped.delete();
    for (int i = 0; i < 3; i++) send_byte(8'($urandom), i == 2);
    key_valid = 1'b1; key_data = 8'h0F;
    @(negedge clk);
    chk1("t4_key_blocked", key_ready, 1'b0);
    tick();
    load_key(8'h0F);
    b0 = 8'($urandom);
    send_byte(b0, 1'b0);
    for (int i = 1; i < 4; i++) send_byte(8'($urandom), i == 3);
    wait_idle();
    chki("t4_count", popped.size(), 7);
    if (popped.size() == 7) chk9("t4_newkey", popped[3], {1'b0, rotl(b0 ^ 8'h0F, 7 & SEED_MASK)});

    // Reset with bytes buffered
    m_ready = 1'b0;
    for (int i = 0; i < 3; i++) send_byte(8'($urandom), 1'b0);
    repeat (4) tick();
    @(negedge clk);
    chk1("t5_buffered", m_valid, 1'b1);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk1("t5_mvalid", m_valid, 1'b0);
    chk1("t5_busy", busy, 1'b0);
    chk1("t5_sready", s_ready, 1'b0);
    chk1("t5_idle", key_ready, 1'b1);
    chk8("t5_key", enc_key, 8'h00);
    tick();
    m_ready = 1'b1;

    // Rotation start for key 03
    popped.delete();
    load_key(8'h03);
    send_byte(8'h00, 1'b1);
    wait_idle();
    chki("t6_count", popped.size(), 1);
    if (popped.size() == 1) chk8("t6_seed", popped[0][7:0], (SEED_MASK != 0) ? 8'h18 : 8'h03);

    // Random packets, keys and sink back-pressure
    rnd_mr = 1'b1;
    for (int p = 0; p < 8; p++) begin
      if ($urandom_range(0, 1) == 1) load_key(8'($urandom));
      len = $urandom_range(1, 12);
      for (int i = 0; i < len; i++) begin
        repeat ($urandom_range(0, 2)) tick();
        send_byte(8'($urandom), i == len - 1);
      end
    end
    rnd_mr = 1'b0;
    m_ready = 1'b1;
    wait_idle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
